// File: rtl/gumnut_int_ctrl_if.sv
// gumnut_int_ctrl_if: Gumnut I/O port bus between the CPU (master) and a port peripheral (slave).
interface gumnut_int_ctrl_if;
  logic       port_cyc_i;
  logic       port_stb_i;
  logic       port_we_i;
  logic [7:0] port_adr_i;
  logic [7:0] port_dat_i;
  logic [7:0] port_dat_o;
  logic       port_ack_o;
  modport master (
    output port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
    input  port_dat_o, port_ack_o
  );
  modport slave (
    input  port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
    output port_dat_o, port_ack_o
  );
endinterface

// File: rtl/gumnut_int_ctrl.sv
// gumnut_int_ctrl: prioritised edge-triggered interrupt controller on the Gumnut port bus.
module gumnut_int_ctrl #(
  parameter int         NUM_SRC  = 4,
  parameter logic [7:0] BASE_ADR = 8'hF0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gumnut_int_ctrl_if.slave   bus,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               int_req_o,
  input  logic               int_ack_i
);
  localparam logic [7:0] SRC_M = 8'((1 << NUM_SRC) - 1);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [7:0]         pend_q, pend_d, mask_q, mask_d, vec_q, vec_d, dat_q, dat_d;
  logic [7:0]         active, take, rdata;
  logic               gen_q, gen_d, ack_q, hit, wr;
  logic [1:0]         off;
  logic [2:0]         id;
  always_comb begin
    off    = bus.port_adr_i[1:0];
    hit    = bus.port_cyc_i & bus.port_stb_i & (bus.port_adr_i[7:2] == BASE_ADR[7:2]) & ~ack_q;
    wr     = hit & bus.port_we_i;
    active = gen_q ? pend_q & mask_q : 8'h00;
    id     = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) id = active[i] ? 3'(i) : id;
    take    = 8'h00;
    state_d = state_q;
    vec_d   = vec_q;
    if (state_q == IDLE && active != 8'h00) state_d = REQ;
    else if (state_q == REQ && int_ack_i) begin
      state_d = SERVICE;
      take    = active != 8'h00 ? 8'h01 << id : 8'h00;
      vec_d   = active != 8'h00 ? {5'b10000, id} : 8'h00;
    end else if (state_q == SERVICE && wr && off == 2'd2) begin
      state_d = IDLE;
      vec_d   = 8'h00;
    end
    // a new edge beats a software or acknowledge clear in the same cycle
    pend_d = (pend_q & ~(wr && off == 2'd0 ? bus.port_dat_i : 8'h00) & ~take) | 8'(irq_i & ~irq_q);
    mask_d = wr && off == 2'd1 ? bus.port_dat_i & SRC_M : mask_q;
    gen_d  = wr && off == 2'd3 ? bus.port_dat_i[0] : gen_q;
    rdata  = off == 2'd0 ? pend_q : off == 2'd1 ? mask_q : off == 2'd2 ? vec_q : {7'b0, gen_q};
    dat_d  = hit && !bus.port_we_i ? rdata : 8'h00;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      vec_q   <= 8'h00;
      gen_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      gen_q   <= gen_d;
      ack_q   <= hit;
      dat_q   <= dat_d;
    end
  end
  assign int_req_o      = state_q == REQ;
  assign bus.port_ack_o = ack_q;
  assign bus.port_dat_o = dat_q;
endmodule

// File: tb/tb_gumnut_int_ctrl.sv
// tb_gumnut_int_ctrl: directed and randomized checks of the interrupt controller against a transaction-level model.
module tb_gumnut_int_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b0, int_ack_i = 1'b0;
  logic [3:0] irq_i = 4'h0;
  logic       int_req_o;
  gumnut_int_ctrl_if bus();
  gumnut_int_ctrl #(.NUM_SRC(4), .BASE_ADR(8'hF0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave),
    .irq_i(irq_i), .int_req_o(int_req_o), .int_ack_i(int_ack_i)
  );
  always #5 clk_i = ~clk_i;
  int         checks = 0, errs = 0;
  logic [7:0] m_pend, m_mask, m_vec;
  logic       m_gen, m_req, m_srv;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  function automatic void m_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_vec = 8'h00;
    m_gen = 1'b0; m_req = 1'b0; m_srv = 1'b0;
  endfunction
  // the CPU sees a request whenever an enabled, unmasked source is pending and nothing is in service
  function automatic void settle();
    if (!m_req && !m_srv && m_gen && (m_pend & m_mask) != 8'h00) m_req = 1'b1;
  endfunction
  task automatic access(input logic we, input logic [7:0] adr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic ok);
    tick(1);
    bus.port_cyc_i = 1'b1; bus.port_stb_i = 1'b1; bus.port_we_i = we;
    bus.port_adr_i = adr; bus.port_dat_i = wd;
    ok = 1'b0; rd = 8'h00;
    for (int i = 0; i < 4 && !ok; i++) begin
      tick(1);
      if (bus.port_ack_o) begin
        ok = 1'b1;
        rd = bus.port_dat_o;
      end
    end
    bus.port_cyc_i = 1'b0; bus.port_stb_i = 1'b0; bus.port_we_i = 1'b0;
  endtask
  task automatic mw(input logic [7:0] adr, input logic [7:0] d);
    logic [7:0] rd;
    logic       ok;
    access(1'b1, adr, d, rd, ok);
    chk("write_ack", 8'(ok), 8'h01);
    case (adr[1:0])
      2'd0: m_pend &= ~d;
      2'd1: m_mask = d & 8'h0F;
      2'd2: if (m_srv) begin m_srv = 1'b0; m_vec = 8'h00; end
      default: m_gen = d[0];
    endcase
    settle();
  endtask
  task automatic rc(input logic [7:0] adr, input string tag);
    logic [7:0] rd, exp;
    logic       ok;
    access(1'b0, adr, 8'h00, rd, ok);
    exp = adr[1:0] == 2'd0 ? m_pend : adr[1:0] == 2'd1 ? m_mask : adr[1:0] == 2'd2 ? m_vec : {7'b0, m_gen};
    chk({tag, "_ack"}, 8'(ok), 8'h01);
    chk(tag, rd, exp);
  endtask
  task automatic pulse(input logic [3:0] bits);
    tick(1);
    irq_i = bits;
    tick(1);
    irq_i = 4'h0;
    m_pend |= 8'(bits);
    settle();
  endtask
  task automatic do_ack();
    logic [7:0] act, low;
    tick(1);
    int_ack_i = 1'b1;
    tick(1);
    int_ack_i = 1'b0;
    act = m_gen ? m_pend & m_mask : 8'h00;
    low = act & (~act + 8'h01);
    m_vec = act != 8'h00 ? 8'h80 | 8'($clog2(low)) : 8'h00;
    m_pend &= ~low;
    m_req = 1'b0;
    m_srv = 1'b1;
    chk("req_after_ack", 8'(int_req_o), 8'h00);
  endtask
  task automatic chk_req(input string tag);
    chk(tag, 8'(int_req_o), 8'(m_req));
  endtask
  initial begin
    logic [7:0] r;
    bus.port_cyc_i = 1'b0; bus.port_stb_i = 1'b0; bus.port_we_i = 1'b0;
    bus.port_adr_i = 8'h00; bus.port_dat_i = 8'h00;
    m_reset();
    #2;
    chk("rst_req", 8'(int_req_o), 8'h00);
    chk("rst_ack", 8'(bus.port_ack_o), 8'h00);
    chk("rst_dat", bus.port_dat_o, 8'h00);
    tick(2);
    rst_i = 1'b1;
    // single source: latency and vector
    mw(8'hF1, 8'h0F);
    mw(8'hF3, 8'h01);
    pulse(4'b0100);
    chk("req_latency_1", 8'(int_req_o), 8'h00);
    tick(1);
    chk("req_latency_2", 8'(int_req_o), 8'h01);
    rc(8'hF0, "pend_one");
    chk("pend_one_const", m_pend, 8'h04);
    do_ack();
    rc(8'hF2, "vec_one");
    chk("vec_one_const", m_vec, 8'h82);
    rc(8'hF0, "pend_after_ack");
    mw(8'hF2, 8'h5A);
    tick(2);
    chk_req("idle_after_eoi");
    // two simultaneous edges, serviced in priority order
    pulse(4'b1010);
    tick(2);
    chk_req("req_pair");
    do_ack();
    rc(8'hF2, "vec_pair_1");
    chk("vec_pair_1_const", m_vec, 8'h81);
    tick(2);
    chk("no_req_in_service", 8'(int_req_o), 8'h00);
    mw(8'hF2, 8'h00);
    tick(1);
    chk("rereq_after_eoi", 8'(int_req_o), 8'h01);
    do_ack();
    rc(8'hF2, "vec_pair_2");
    chk("vec_pair_2_const", m_vec, 8'h83);
    mw(8'hF2, 8'h00);
    // masked source stays pending until unmasked
    mw(8'hF1, 8'h00);
    pulse(4'b0001);
    tick(2);
    chk_req("masked_no_req");
    rc(8'hF0, "pend_masked");
    mw(8'hF1, 8'h01);
    tick(1);
    chk("unmask_req", 8'(int_req_o), 8'h01);
    // clear all pending while requesting: spurious acknowledge
    mw(8'hF0, 8'hFF);
    chk_req("req_held_after_clear");
    do_ack();
    rc(8'hF2, "vec_spurious");
    chk("vec_spurious_const", m_vec, 8'h00);
    mw(8'hF2, 8'h00);
    tick(2);
    chk_req("idle_after_spurious");
    // out-of-range and held strobe
    tick(1);
    bus.port_cyc_i = 1'b1; bus.port_stb_i = 1'b1; bus.port_adr_i = 8'hF4;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("oor_ack", 8'(bus.port_ack_o), 8'h00);
      chk("oor_dat", bus.port_dat_o, 8'h00);
    end
    bus.port_adr_i = 8'hF1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("held_ack", 8'(bus.port_ack_o), 8'(k % 2 == 0));
      chk("held_dat", bus.port_dat_o, k % 2 == 0 ? m_mask : 8'h00);
    end
    bus.port_cyc_i = 1'b0; bus.port_stb_i = 1'b0;
    // randomized rounds
    mw(8'hF3, 8'h01);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) mw(8'hF3, 8'($urandom_range(0, 1)));
      else mw(8'hF3, 8'h01);
      mw(8'hF1, 8'($urandom));
      pulse(4'($urandom));
      if ($urandom_range(0, 3) == 0) mw(8'hF0, 8'($urandom));
      tick(2);
      chk_req("rnd_req");
      rc(8'hF0, "rnd_pend");
      rc(8'hF1, "rnd_mask");
      rc(8'hF3, "rnd_ctrl");
      if (m_req) begin
        do_ack();
        rc(8'hF2, "rnd_vec");
        r = 8'($urandom);
        mw(8'hF2, r);
        rc(8'hF2, "rnd_vec_eoi");
      end
      tick(2);
      chk_req("rnd_req_end");
    end
    // asynchronous reset in the middle of service
    mw(8'hF3, 8'h01);
    mw(8'hF1, 8'h0F);
    pulse(4'b0001);
    tick(2);
    if (m_req) do_ack();
    chk("srv_before_reset", 8'(m_srv), 8'h01);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    m_reset();
    #1;
    chk("arst_req", 8'(int_req_o), 8'h00);
    chk("arst_ack", 8'(bus.port_ack_o), 8'h00);
    chk("arst_dat", bus.port_dat_o, 8'h00);
    tick(1);
    rst_i = 1'b1;
    rc(8'hF0, "arst_pend");
    rc(8'hF1, "arst_mask");
    rc(8'hF2, "arst_vec");
    rc(8'hF3, "arst_ctrl");
    rst_i = 1'b0;
    tick(1);
    irq_i = 4'b0001;
    tick(1);
    rst_i = 1'b1;
    m_reset();
    tick(1);
    m_pend = 8'h01;
    rc(8'hF0, "high_at_release");
    irq_i = 4'h0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
